// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_wr_ctrl_pkg: shared state encoding, default sizes and helpers for the FIFO write controller.
package fifo_wr_ctrl_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 256;
    localparam int SETTLE_W       = 4;
    localparam int BCNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE,
        ST_DONE,
        ST_HALT
    } wr_state_e;

    function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_pattern.sv
// fifo_wr_pattern: incrementing data pattern; advances only on an accepted write.
module fifo_wr_pattern #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] value_q, value_d;

    always_comb value_d = adv ? value_q + 1'b1 : value_q;

    always_ff @(posedge clk) begin
        if (rst) value_q <= DATA_INIT;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: waits for an empty FIFO, settles, then streams one burst of the data pattern
// until full or FIFO_DEPTH words are written; counts bursts and optionally halts.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int                SETTLE_CYC = 2,
    parameter logic [DATA_W-1:0] DATA_INIT  = '0,
    parameter int                BURSTS     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty_flag,
    input  logic              fifo_full_flag,
    output logic              fifo_wr_flag,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              burst_done,
    output logic [BCNT_W-1:0] burst_cnt,
    output logic              halted
);

    localparam int WC_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         state_q, state_d;
    logic [WC_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                wr_flag_q, wr_flag_d;
    logic                accept, last_word, settled;

    // full takes priority over the last-word exit: a write seen with full is never counted
    assign accept    = (state_q == ST_WRITE) && wr_flag_q && !fifo_full_flag;
    assign last_word = wr_cnt_q == WC_W'(FIFO_DEPTH - 1);
    assign settled   = settle_cnt_q == SETTLE_W'(SETTLE_CYC);

    fifo_wr_pattern #(
        .DATA_W    (DATA_W),
        .DATA_INIT (DATA_INIT)
    ) u_pattern (
        .clk   (clk),
        .rst   (rst),
        .adv   (accept),
        .value (fifo_wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            settle_cnt_q <= '0;
            burst_cnt_q  <= '0;
            wr_flag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            wr_flag_q    <= wr_flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable && fifo_empty_flag) state_d = ST_SETTLE;
            ST_SETTLE: if (settled) state_d = ST_WRITE;
            ST_WRITE:  if (fifo_full_flag || last_word) state_d = ST_DONE;
            ST_DONE:   state_d = (BURSTS != 0 && burst_cnt_d == BCNT_W'(BURSTS)) ? ST_HALT : ST_IDLE;
            default:   state_d = state_q;
        endcase
    end

    // the write strobe is registered and high for exactly the cycles spent in WRITE
    always_comb begin
        settle_cnt_d = (state_q == ST_IDLE) ? '0 : (state_q == ST_SETTLE) ? settle_cnt_q + 1'b1 : settle_cnt_q;
        wr_cnt_d     = (state_q == ST_DONE) ? '0 : accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
        burst_cnt_d  = (state_q == ST_DONE) ? sat_inc(burst_cnt_q) : burst_cnt_q;
        wr_flag_d    = state_d == ST_WRITE;
    end

    always_comb begin
        fifo_wr_flag = wr_flag_q;
        busy         = (state_q == ST_SETTLE) || (state_q == ST_WRITE);
        burst_done   = state_q == ST_DONE;
        halted       = state_q == ST_HALT;
        burst_cnt    = burst_cnt_q;
    end

endmodule
